// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Also holds the counter-width helper and the divide-by-zero result functions.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // A zero divisor yields an all-ones quotient and hands back the untouched dividend.
    function automatic logic [63:0] dz_quotient(input int w);
        return width_mask(w);
    endfunction

    function automatic logic [63:0] dz_remainder(input logic [63:0] dividend, input int w);
        return dividend & width_mask(w);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = value;
        if (negate) begin
            result = (~value) + WIDTH'(1);
        end
    end

endmodule

// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider, signed/unsigned, valid/ready on both sides.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the shift/subtract steps.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DZ_QUO = WIDTH'(dz_quotient(WIDTH));

    div_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dividend_q;
    logic             q_neg_q, r_neg_q, dz_q;

    logic [WIDTH-1:0] a_mag, b_mag, q_fixed, r_fixed;
    logic [WIDTH:0]   shifted, trial;
    logic             accept;

    assign accept = in_valid && in_ready;

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .value  (dividend),
        .negate (in_signed && dividend[WIDTH-1]),
        .result (a_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .value  (divisor),
        .negate (in_signed && divisor[WIDTH-1]),
        .result (b_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .value  (quo_q),
        .negate (q_neg_q),
        .result (q_fixed)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .value  (rem_q),
        .negate (r_neg_q),
        .result (r_fixed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                CALC: if (dz_q || cnt_q == LAST_STEP) state_d = DONE;
`else
                CALC: if (cnt_q == LAST_STEP) state_d = DONE;
`endif
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !flush;
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC) || (state_q == DONE);
    end

    // Shifted partial remainder is one bit wider so the trial subtract sign is visible.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            dividend_q <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= a_mag;
            dvsr_q     <= b_mag;
            dividend_q <= dividend;
            q_neg_q    <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_q    <= in_signed && dividend[WIDTH-1];
            dz_q       <= (divisor == '0);
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            if (!trial[WIDTH]) begin
                rem_q <= trial[WIDTH-1:0];
            end else begin
                rem_q <= shifted[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        quotient  = q_fixed;
        remainder = r_fixed;
        if (dz_q) begin
            quotient  = DZ_QUO;
            remainder = WIDTH'(dz_remainder(64'(dividend_q), WIDTH));
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit (WIDTH=32): directed table, random ops
// against a plain-arithmetic model, and flush/backpressure sequences.
module tb_iter_div_unit;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          busy;

    int errors = 0;
    int checks = 0;

    iter_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sgn;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: truncating division with a sign-of-dividend remainder, zero divisor forced.
    function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int expLatency(input logic [W-1:0] b);
        return (FAST_ZERO && b == 0) ? 1 : W;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                 output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        dividend  = a;
        divisor   = b;
        in_signed = sgn;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic finishOp(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checkOutput({name, "_in_ready_after_hs"}, 64'(in_ready), 64'd1);
        checkOutput({name, "_out_valid_after_hs"}, 64'(out_valid), 64'd0);
        checkOutput({name, "_busy_after_hs"}, 64'(busy), 64'd0);
    endtask

    task automatic runCheck(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit sgn, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
        int lat;
        applyStimulus(a, b, sgn, lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'(expLatency(b)));
        checkOutput({name, "_quotient"}, 64'(quotient), 64'(exp_q));
        checkOutput({name, "_remainder"}, 64'(remainder), 64'(exp_r));
        finishOp(name);
    endtask

    initial begin
        vec_t         vecs[$];
        logic [W-1:0] ra, rb, mq, mr, hold_q, hold_r;
        bit           rs;
        int           lat;
        bit           saw_valid;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_quotient", 64'(quotient), 64'd0);
        checkOutput("reset_remainder", 64'(remainder), 64'd0);

        vecs.push_back('{"udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2});
        vecs.push_back('{"sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        vecs.push_back('{"sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1});
        vecs.push_back('{"sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0});
        vecs.push_back('{"sdiv_zero", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5});
        vecs.push_back('{"udiv_zero", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5});
        vecs.push_back('{"sdiv_negzero", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
        vecs.push_back('{"udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{"udiv_small_big", 32'd3, 32'hFFFF_FFF0, 1'b0, 32'd0, 32'd3});

        foreach (vecs[i]) begin
            runCheck(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_q, vecs[i].exp_r);
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom();
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom() >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            refDiv(ra, rb, rs, mq, mr);
            runCheck($sformatf("rand%0d", i), ra, rb, rs, mq, mr);
        end

        dividend  = 32'd1000;
        divisor   = 32'd7;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        checkOutput("flush_busy", 64'(busy), 64'd0);
        saw_valid = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("flush_no_result", 64'(saw_valid), 64'd0);
        runCheck("after_flush_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        dividend = 32'd9;
        divisor  = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        checkOutput("flush_idle_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput("flush_idle_no_accept", 64'(busy), 64'd0);
        checkOutput("flush_idle_ready_back", 64'(in_ready), 64'd1);

        applyStimulus(32'd1000, 32'd33, 1'b0, lat);
        checkOutput("bp_latency", 64'(lat), 64'(W));
        hold_q = quotient;
        hold_r = remainder;
        checkOutput("bp_quotient", 64'(hold_q), 64'd30);
        checkOutput("bp_remainder", 64'(hold_r), 64'd10);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_out_valid_hold", 64'(out_valid), 64'd1);
            checkOutput("bp_quotient_hold", 64'(quotient), 64'd30);
            checkOutput("bp_remainder_hold", 64'(remainder), 64'd10);
            checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        finishOp("bp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
